data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the datapath's load/store interface. Accepts one request at a time
//  on a valid/ready handshake, models WAIT_STATES of memory latency, then returns a
//  one-cycle response. Sits between Data_Path (ALUResult=address, WriteData=store data)
//  and the word-organised data RAM. Used for multi-cycle/stall-capable core variants.
// PARAMETERS
//  DEPTH_WORDS  256           number of 32-bit words; power of two, >=2
//  WAIT_STATES  2             extra cycles between accept and response; 0..15
//  ADDR_BASE    32'h0000_0000 byte address mapped to word 0
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept; high only in IDLE
//  req_we     in   1   1=store, 0=load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, byte lanes aligned to address bits [1:0]=00
//  req_be     in   4   byte enables; bit i writes wdata[8i+7:8i]
//  rsp_valid  out  1   response strobe, exactly one cycle per accepted request
//  rsp_rdata  out  32  word read (load), or post-write word contents (store)
//  rsp_err    out  1   access fault (ACCESS_FAULT_EN only; otherwise tied 0)
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//    rsp_err=0, wait counter=0. RAM contents NOT reset.
//  - FSM: IDLE -> BUSY on accept (req_valid && req_ready); latch we/addr/wdata/be,
//    counter <= WAIT_STATES. If WAIT_STATES==0, IDLE -> RESP directly.
//    BUSY: counter decrements each cycle; at counter==1 -> RESP.
//    RESP: rsp_valid=1 for one cycle, then -> IDLE. No response backpressure.
//  - Latency: accept edge T -> rsp_valid high in cycle T+WAIT_STATES+1.
//    Throughput: one request per WAIT_STATES+2 cycles.
//  - Access commits on the edge entering RESP: store updates enabled bytes only;
//    rsp_rdata registered on the same edge (loads: current word; stores: merged word).
//  - Word index = (req_addr - ADDR_BASE) >> 2, taken modulo DEPTH_WORDS (wrap-around);
//    req_addr[1:0] ignored.
//  - Store with req_be==4'b0000: no RAM change, response still issued.
//  - req_valid while not IDLE: ignored (req_ready=0); requester must hold it.
//  - Latched request fields are stable from accept to response; input changes after
//    accept have no effect.
//  - rsp_rdata holds its last value outside RESP; rsp_err is only meaningful with
//    rsp_valid.
//  - Reset mid-operation (BUSY or RESP): pending request dropped, uncommitted store
//    never written, FSM returns to IDLE.
// CONFIGURATION
//  ACCESS_FAULT_EN defined:
//    - Request faults if (req_addr - ADDR_BASE) >= DEPTH_WORDS*4, or req_addr[1:0]!=0
//      with any req_be set.
//    - Faulting request: no RAM write, rsp_rdata=0, rsp_err=1 with rsp_valid, same
//      latency as a normal request.
//  ACCESS_FAULT_EN undefined: no fault checks, addresses wrap, rsp_err constant 0.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0.
//  2 WAIT_STATES=2: store addr 0x10, wdata 0xDEADBEEF, be=1111, accepted at T ->
//    rsp_valid at T+3 only. Then load 0x10 -> rsp_rdata=0xDEADBEEF.
//  3 Byte merge: store 0x11223344 be=1111, then store 0xAABBCCDD be=0101 to the same
//    word -> load returns 0x11BB33DD.
//  4 Wrap (no macro), DEPTH_WORDS=256: store 0x5A5A5A5A to 0x400 -> load 0x000
//    returns 0x5A5A5A5A.
//  5 Reset mid-op: store 0xFFFFFFFF to 0x20 over old 0x0, reset=0 in BUSY, release,
//    load 0x20 -> 0x00000000.
//  6 ACCESS_FAULT_EN: load 0x400 -> rsp_err=1, rsp_rdata=0. Store to 0x22 be=0001 ->
//    rsp_err=1, word unchanged.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder with WAIT_STATES latency.
// Ports: clk, reset(n), req_* handshake in, rsp_* strobe out; ACCESS_FAULT_EN.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic          lat_we;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          lat_flt;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] req_idx;
  logic          req_flt;
  logic          accept;

  assign off     = req_addr - ADDR_BASE;
  assign req_idx = off[AW+1:2];
  assign accept  = req_valid && (state == IDLE);

`ifdef ACCESS_FAULT_EN
  assign req_flt = (off >= 32'(DEPTH_WORDS * 4)) ||
                   ((req_addr[1:0] != 2'b00) && (|req_be));
`else
  logic unused_off;
  assign req_flt    = 1'b0;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
`endif

  // With zero wait states the access commits on the
  // accept edge, before the latches hold the request.
  logic          a_we;
  logic [AW-1:0] a_idx;
  logic [31:0]   a_wdata;
  logic [3:0]    a_be;
  logic          a_flt;

  always_comb begin
    if (state == IDLE) begin
      a_we    = req_we;
      a_idx   = req_idx;
      a_wdata = req_wdata;
      a_be    = req_be;
      a_flt   = req_flt;
    end else begin
      a_we    = lat_we;
      a_idx   = lat_idx;
      a_wdata = lat_wdata;
      a_be    = lat_be;
      a_flt   = lat_flt;
    end
  end

  logic [31:0] cur;
  logic [31:0] merged;

  assign cur = mem[a_idx];

  always_comb begin
    merged = cur;
    for (int i = 0; i < 4; i++) begin
      if (a_be[i]) merged[8*i +: 8] = a_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic commit;
  logic wr_en;

  assign commit = (state_nxt == RESP);
  // Gate with reset so an asserted reset can never
  // let a pending store reach the RAM.
  assign wr_en  = commit && reset && a_we &&
                  !a_flt && (|a_be);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      lat_flt   <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_idx   <= req_idx;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        lat_flt   <= req_flt;
      end
      if (commit) begin
        if (a_flt)     rsp_rdata <= 32'd0;
        else if (a_we) rsp_rdata <= merged;
        else           rsp_rdata <= cur;
        rsp_err <= a_flt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[a_idx] <= merged;
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed + random checks
// against a word-array model of the responder.
module tb_data_mem_responder;

  localparam int WS  = 2;
  localparam int DW  = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int passes = 0;
  int total  = 0;

  logic [31:0] mdl [DW];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS(DW),
    .WAIT_STATES(WS),
    .ADDR_BASE  (32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  function automatic bit is_flt(input logic [31:0] a,
                                input logic [3:0] be);
`ifdef ACCESS_FAULT_EN
    return (a >= 32'(DW * 4)) ||
           ((a[1:0] != 2'b00) && (be != 4'b0));
`else
    return (a[1:0] == 2'b00) && (be == 4'hF) && 1'b0;
`endif
  endfunction

  task automatic do_req(input string tag,
                        input logic we,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [3:0] be,
                        input logic [31:0] exp_rd,
                        input logic exp_err);
    int  n;
    bit  got;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    n   = 1;
    got = 1'b0;
    while (!got && n <= 40) begin
      if (rsp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, " latency"}, 32'(n), 32'(WS + 1));
    last_rd = rsp_rdata;
    if (got) begin
      chk({tag, " rdata"}, rsp_rdata, exp_rd);
      chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
      @(negedge clk);
      chk({tag, " one-shot"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic mstore(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] be);
    int          idx;
    logic [31:0] nw;
    idx = int'((a >> 2) % DW);
    nw  = mdl[idx];
    for (int i = 0; i < 4; i++)
      if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
    if (is_flt(a, be)) begin
      do_req(tag, 1'b1, a, wd, be, 32'd0, 1'b1);
    end else begin
      do_req(tag, 1'b1, a, wd, be, nw, 1'b0);
      mdl[idx] = nw;
    end
  endtask

  task automatic mload(input string tag,
                       input logic [31:0] a);
    int idx;
    idx = int'((a >> 2) % DW);
    if (is_flt(a, 4'hF))
      do_req(tag, 1'b0, a, 32'd0, 4'hF, 32'd0, 1'b1);
    else
      do_req(tag, 1'b0, a, 32'd0, 4'hF, mdl[idx], 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    for (int i = 0; i < DW; i++) mdl[i] = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst valid", 32'(rsp_valid), 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    mstore("st10", 32'h10, 32'hDEADBEEF, 4'hF);
    mload("ld10", 32'h10);
    chk("ld10 value", last_rd, 32'hDEADBEEF);

    mstore("st30a", 32'h30, 32'h11223344, 4'hF);
    mstore("st30b", 32'h30, 32'hAABBCCDD, 4'b0101);
    mload("ld30", 32'h30);
    chk("merge value", last_rd, 32'h11BB33DD);
    mstore("st30z", 32'h30, 32'hCAFEF00D, 4'b0000);
    mload("ld30z", 32'h30);
    chk("be0 value", last_rd, 32'h11BB33DD);

`ifndef ACCESS_FAULT_EN
    mstore("st400", 32'h400, 32'h5A5A5A5A, 4'hF);
    mload("ld000", 32'h000);
    chk("wrap value", last_rd, 32'h5A5A5A5A);
`endif

    mstore("st20", 32'h20, 32'h0, 4'hF);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hFFFFFFFF;
    req_be    = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid ready", 32'(req_ready), 32'd1);
    chk("mid valid", 32'(rsp_valid), 32'd0);
    chk("mid rdata", rsp_rdata, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("no rsp", 32'(rsp_valid), 32'd0);
    mload("ld20", 32'h20);
    chk("drop value", last_rd, 32'h0);

`ifdef ACCESS_FAULT_EN
    mload("fld400", 32'h400);
    mstore("fst22", 32'h22, 32'h000000EE, 4'b0001);
    mload("fld20", 32'h20);
    chk("flt word", last_rd, 32'h0);
`endif

    for (int i = 0; i < 16; i++)
      mstore("init", 32'(((i * 17) % DW) << 2),
             $urandom, 4'hF);
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(15, 0));
      a = 32'(((k * 17) % DW) << 2);
`ifndef ACCESS_FAULT_EN
      a = a | ($urandom & 32'hFFFF_FC00)
            | 32'($urandom_range(3, 0));
`endif
      if ($urandom_range(1, 0) == 1)
        mstore("rst", a, $urandom, 4'($urandom));
      else
        mload("rld", a);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
